// File: rtl/sync_edge_filter.sv
// sync_edge_filter
//   Multi-channel conditioner for asynchronous inputs such as buttons, switches,
//   external IRQ lines and slow-domain status bits. Each channel has:
//     - a SYNC_LEN-deep synchronizer
//     - a counter-based glitch filter, which accepts a new level only after it
//       has held for FILT_CNT consecutive synced cycles
//     - registered 1-cycle rise/fall pulses
//     - a sticky pending flag with write-1-to-clear
//
// Ports
//   clk      single clock domain
//   rst_n    asynchronous active-low reset
//   async_i  [WIDTH] asynchronous inputs
//   clr_i    [WIDTH] write-1-to-clear for pend_o (set wins over clear)
//   level_o  [WIDTH] filtered level
//   rise_o   [WIDTH] 1-cycle pulse on level 0->1
//   fall_o   [WIDTH] 1-cycle pulse on level 1->0
//   pend_o   [WIDTH] sticky edge flags, selected by EDGE_MODE
//   irq_o    OR of pend_o
module sync_edge_filter #(
    parameter int         WIDTH     = 8,
    parameter int         SYNC_LEN  = 3,
    parameter int         FILT_CNT  = 4,
    parameter logic       INIT      = 1'b1,
    parameter logic [1:0] EDGE_MODE = 2'b11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] async_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] pend_o,
    output logic             irq_o
);
    localparam int            CW       = (FILT_CNT > 1) ? $clog2(FILT_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CNT - 1);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
        logic [SYNC_LEN-1:0] sync_q;
        logic [CW-1:0]       cnt;
        logic                lvl, rise, fall, pend;
        logic                synced, accept, rise_nx, fall_nx, set;

        // The synchronizer is a plain shift with no logic between stages.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync_q <= {SYNC_LEN{INIT}};
            else        sync_q <= {sync_q[SYNC_LEN-2:0], async_i[i]};
        end

        assign synced = sync_q[SYNC_LEN-1];
        // cnt counts consecutive mismatching cycles already seen. A new value
        // is accepted on the FILT_CNT-th consecutive mismatch.
        assign accept  = (synced != lvl) && (cnt == CNT_LAST);
        assign rise_nx = accept & synced;
        assign fall_nx = accept & ~synced;
        assign set     = (rise_nx & EDGE_MODE[0]) | (fall_nx & EDGE_MODE[1]);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl  <= INIT;
                cnt  <= '0;
                rise <= 1'b0;
                fall <= 1'b0;
                pend <= 1'b0;
            end else begin
                rise <= rise_nx;
                fall <= fall_nx;
                // A set in the same cycle as a clear takes priority.
                pend <= (pend & ~clr_i[i]) | set;
                if (synced == lvl) begin
                    cnt <= '0;
                end else if (accept) begin
                    lvl <= synced;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign level_o[i] = lvl;
        assign rise_o[i]  = rise;
        assign fall_o[i]  = fall;
        assign pend_o[i]  = pend;
    end

    assign irq_o = |pend_o;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Testbench for sync_edge_filter.
// Two instances share the same stimulus:
//   dut    EDGE_MODE=2'b11
//   dut_m  EDGE_MODE=2'b01
// The reference model describes the filter as a sliding window. A level is
// accepted when the last FILT_CNT synced samples since reset all differ from
// the current level.
module tb_sync_edge_filter;
    localparam int   W    = 4;
    localparam int   SL   = 3;
    localparam int   FC   = 4;
    localparam logic INIT = 1'b1;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b1;
    logic         clk_en = 1'b0;
    logic [W-1:0] async_v = '0;
    logic [W-1:0] clr_v   = '0;
    logic [W-1:0] level, rise, fall, pend;
    logic [W-1:0] level_m, rise_m, fall_m, pend_m;
    logic         irq, irq_m;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    logic [W-1:0] syncq[$];
    logic [W-1:0] win[$];
    logic [W-1:0] m_lvl, m_rise, m_fall, m_pend, m_pend_m;

    sync_edge_filter #(.WIDTH(W), .SYNC_LEN(SL), .FILT_CNT(FC), .INIT(INIT), .EDGE_MODE(2'b11)) dut (
        .clk(clk), .rst_n(rst_n), .async_i(async_v), .clr_i(clr_v),
        .level_o(level), .rise_o(rise), .fall_o(fall), .pend_o(pend), .irq_o(irq));

    sync_edge_filter #(.WIDTH(W), .SYNC_LEN(SL), .FILT_CNT(FC), .INIT(INIT), .EDGE_MODE(2'b01)) dut_m (
        .clk(clk), .rst_n(rst_n), .async_i(async_v), .clr_i(clr_v),
        .level_o(level_m), .rise_o(rise_m), .fall_o(fall_m), .pend_o(pend_m), .irq_o(irq_m));

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_lvl    = {W{INIT}};
        m_rise   = '0;
        m_fall   = '0;
        m_pend   = '0;
        m_pend_m = '0;
        syncq.delete();
        win.delete();
        repeat (SL) syncq.push_back({W{INIT}});
    endtask

    task automatic model_step();
        logic [W-1:0] s, acc;
        syncq.push_back(async_v);
        s = syncq.pop_front();
        win.push_back(s);
        if (win.size() > FC) void'(win.pop_front());
        acc = '0;
        for (int c = 0; c < W; c++) begin
            if (win.size() == FC) begin
                acc[c] = 1'b1;
                foreach (win[k]) if (win[k][c] == m_lvl[c]) acc[c] = 1'b0;
            end
        end
        m_rise   = acc & s;
        m_fall   = acc & ~s;
        m_lvl    = (m_lvl & ~acc) | (s & acc);
        m_pend   = (m_pend & ~clr_v) | m_rise | m_fall;
        m_pend_m = (m_pend_m & ~clr_v) | m_rise;
    endtask

    task automatic compare();
        chk("level",   level,          m_lvl);
        chk("rise",    rise,           m_rise);
        chk("fall",    fall,           m_fall);
        chk("pend",    pend,           m_pend);
        chk("irq",     irq,            |m_pend);
        chk("level_m", level_m,        m_lvl);
        chk("edge_m",  {rise_m, fall_m}, {m_rise, m_fall});
        chk("pend_m",  pend_m,         m_pend_m);
        chk("irq_m",   irq_m,          |m_pend_m);
    endtask

    // One clock: the model advances on the posedge and outputs are compared
    // on the following negedge. Inputs are changed only between steps.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        @(negedge clk);
        compare();
    endtask

    task automatic settle(input int n);
        repeat (n) step();
    endtask

    task automatic clear_all();
        clr_v = '1;
        step();
        clr_v = '0;
    endtask

    // Called right after a negedge. Reset is asserted between clock edges, so
    // the compare checks that it takes effect without a clock.
    task automatic mid_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        settle(cycles);
        rst_n = 1'b1;
    endtask

    initial begin : main
        int first, nr;
        logic seen;
        int hold [W];

        // 1: reset with no clock, then release
        async_v = '0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t1_rst_level", level, 4'hF);
        chk("t1_rst_pend",  pend,  4'h0);
        chk("t1_rst_irq",   irq,   1'b0);
        clk_en = 1'b1;
        settle(2);
        rst_n = 1'b1;
        first = 0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (fall == 4'hF && first == 0) first = e;
        end
        chk("t1_fall_latency", first, 7);
        chk("t1_level", level, 4'h0);
        chk("t1_pend",  pend,  4'hF);
        chk("t1_irq",   irq,   1'b1);

        // 2: a 3-cycle glitch is rejected, a 4-cycle pulse is accepted
        clear_all();
        seen = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            async_v[0] = (e <= 3);
            step();
            if (rise[0] || level[0] || pend[0]) seen = 1'b1;
        end
        chk("t2_glitch3", seen, 1'b0);
        first = 0;
        nr = 0;
        for (int e = 1; e <= 12; e++) begin
            async_v[0] = (e <= 4);
            step();
            if (rise[0]) begin
                nr++;
                if (first == 0) first = e;
            end
            if (e == 7) chk("t2_pend0", pend[0], 1'b1);
        end
        chk("t2_rise_latency", first, 7);
        chk("t2_rise_count",   nr,    1);
        settle(4);

        // 3: set in the same cycle as clear wins; a later clear drops the flag
        async_v[1] = 1'b1;
        settle(8);
        clear_all();
        async_v[1] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            clr_v = (e == 7) ? 4'b0010 : 4'b0000;
            step();
        end
        chk("t3_fall1",      fall[1], 1'b1);
        chk("t3_race_pend1", pend[1], 1'b1);
        clr_v = 4'b0010;
        step();
        clr_v = '0;
        chk("t3_cleared", pend[1], 1'b0);
        chk("t3_irq",     irq,     1'b0);

        // 4: two channels switching in opposite directions on the same cycle
        async_v[3] = 1'b1;
        settle(8);
        async_v[2] = 1'b1;
        async_v[3] = 1'b0;
        settle(7);
        chk("t4_rise", rise, 4'b0100);
        chk("t4_fall", fall, 4'b1000);
        settle(2);

        // 5: with rise-only mode, a fall still pulses but does not set pend
        clear_all();
        async_v[0] = 1'b1;
        settle(8);
        chk("t5_pend_rise", pend_m[0], 1'b1);
        clear_all();
        async_v[0] = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            if (fall_m[0]) seen = 1'b1;
        end
        chk("t5_fall_seen",  seen,      1'b1);
        chk("t5_pend_fall",  pend_m[0], 1'b0);
        chk("t5_irq_m",      irq_m,     1'b0);

        // 6: reset in the middle of filtering discards the counter progress
        async_v[0] = 1'b1;
        settle(8);
        async_v[0] = 1'b0;
        settle(5);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare();
        seen = 1'b0;
        for (int e = 0; e < 3; e++) begin
            step();
            if (rise != 0 || fall != 0) seen = 1'b1;
        end
        chk("t6_no_pulse_in_reset", seen, 1'b0);
        rst_n = 1'b1;
        first = 0;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (fall[0] && first == 0) first = e;
        end
        chk("t6_fall_latency", first, 7);

        // random: hold times around the filter length, random clears, and
        // an occasional reset
        for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 8);
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < W; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    async_v[c] = ~async_v[c];
                    hold[c] = $urandom_range(1, 8);
                end
            end
            clr_v = W'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 399) == 0) mid_reset($urandom_range(1, 3));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
